// File: rtl/snake_pkg.sv
// Shared definitions for the snake input front-end: directions, button indices
// and the opposite-direction helper.
package snake_pkg;

   localparam int CLK_FREQ_HZ    = 100_000_000;
   localparam int DEBOUNCE_10MS  = CLK_FREQ_HZ / 100;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   localparam int BTN_UP          = 0;
   localparam int BTN_DOWN        = 1;
   localparam int BTN_LEFT        = 2;
   localparam int BTN_RIGHT       = 3;
   localparam int BTN_START_PAUSE = 4;
   localparam int BTN_GAME_RESET  = 5;
   localparam int NUM_BTNS        = 6;

   // UP<->DOWN and LEFT<->RIGHT differ only in bit 0
   function automatic dir_t opposite_dir(input dir_t d);
      return d ^ 2'b01;
   endfunction

endpackage

// File: rtl/snake_btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter and a registered
// rising-edge press pulse.
module snake_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic sys_clk,
   input  logic sys_reset,
   input  logic raw_in,
   output logic level_out,
   output logic press_pulse_out
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             level_prev_q, level_prev_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d      = raw_in;
      sync2_d      = sync1_q;
      level_d      = level_q;
      cnt_d        = '0;
      level_prev_d = level_q;
      pulse_d      = level_q & ~level_prev_q;
      // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_TC) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         pulse_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         level_q      <= level_d;
         level_prev_q <= level_prev_d;
         pulse_q      <= pulse_d;
         cnt_q        <= cnt_d;
      end
   end

   assign level_out       = level_q;
   assign press_pulse_out = pulse_q;

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake input front-end: debounces six buttons, queues direction presses and
// releases one committed direction per game tick.
module snake_input_ctrl
   import snake_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int         QUEUE_DEPTH     = 4,
   parameter logic [1:0] INIT_DIR        = DIR_UP
) (
   input  logic                           sys_clk,
   input  logic                           sys_reset,
   input  logic                           btn_up_raw_in,
   input  logic                           btn_down_raw_in,
   input  logic                           btn_left_raw_in,
   input  logic                           btn_right_raw_in,
   input  logic                           btn_start_pause_raw_in,
   input  logic                           btn_game_reset_raw_in,
   input  logic                           game_tick_in,
   output logic [1:0]                     cur_dir_out,
   output logic                           dir_changed_out,
   output logic                           start_pause_pulse_out,
   output logic                           game_reset_pulse_out,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count_out,
   output logic                           dir_drop_out
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

   logic [NUM_BTNS-1:0] btn_raw;
   logic [NUM_BTNS-1:0] btn_press;

   assign btn_raw[BTN_UP]          = btn_up_raw_in;
   assign btn_raw[BTN_DOWN]        = btn_down_raw_in;
   assign btn_raw[BTN_LEFT]        = btn_left_raw_in;
   assign btn_raw[BTN_RIGHT]       = btn_right_raw_in;
   assign btn_raw[BTN_START_PAUSE] = btn_start_pause_raw_in;
   assign btn_raw[BTN_GAME_RESET]  = btn_game_reset_raw_in;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      snake_btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .sys_clk         (sys_clk),
         .sys_reset       (sys_reset),
         .raw_in          (btn_raw[i]),
         .level_out       (),
         .press_pulse_out (btn_press[i])
      );
   end

   dir_t             fifo_q [QUEUE_DEPTH];
   dir_t             fifo_d [QUEUE_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   dir_t             cur_dir_q, cur_dir_d;
   logic             changed_q, changed_d;
   logic             drop_q, drop_d;

   logic             cand_valid;
   dir_t             cand_dir;
   logic [PTR_W-1:0] tail_idx;
   dir_t             ref_dir;
   logic             cand_reject;
   logic             do_pop;
   logic             do_push;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Highest-priority direction wins when several pulse together
   always_comb begin
      cand_valid = 1'b1;
      cand_dir   = DIR_UP;
      if (btn_press[BTN_UP]) begin
         cand_dir = DIR_UP;
      end else if (btn_press[BTN_DOWN]) begin
         cand_dir = DIR_DOWN;
      end else if (btn_press[BTN_LEFT]) begin
         cand_dir = DIR_LEFT;
      end else if (btn_press[BTN_RIGHT]) begin
         cand_dir = DIR_RIGHT;
      end else begin
         cand_valid = 1'b0;
      end
   end

   always_comb begin
      tail_idx    = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PTR_W'(1);
      ref_dir     = (count_q != '0) ? fifo_q[tail_idx] : cur_dir_q;
      cand_reject = (cand_dir == ref_dir) || (cand_dir == opposite_dir(ref_dir));
      do_pop      = game_tick_in && (count_q != '0);
      do_push     = cand_valid && !cand_reject && ((count_q != CNT_FULL) || do_pop);
   end

   always_comb begin
      fifo_d    = fifo_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      cur_dir_d = cur_dir_q;
      changed_d = 1'b0;
      drop_d    = 1'b0;
      // A game reset overrides any push or pop decided in the same cycle
      if (btn_press[BTN_GAME_RESET]) begin
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         cur_dir_d = INIT_DIR;
      end else begin
         drop_d = cand_valid && !do_push;
         if (do_push) begin
            fifo_d[wr_ptr_q] = cand_dir;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            cur_dir_d = fifo_q[rd_ptr_q];
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            changed_d = 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            fifo_q[i] <= DIR_UP;
         end
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         cur_dir_q <= INIT_DIR;
         changed_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         fifo_q    <= fifo_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         cur_dir_q <= cur_dir_d;
         changed_q <= changed_d;
         drop_q    <= drop_d;
      end
   end

   assign cur_dir_out           = cur_dir_q;
   assign dir_changed_out       = changed_q;
   assign dir_drop_out          = drop_q;
   assign queue_count_out       = count_q;
   assign start_pause_pulse_out = btn_press[BTN_START_PAUSE];
   assign game_reset_pulse_out  = btn_press[BTN_GAME_RESET];

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: directed table, hand-timed corner sequences and a
// randomized run against a window-based behavioural model.
module tb_snake_input_ctrl;

   localparam int DB = 4;
   localparam int QD = 4;
   localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SP = 4, B_GR = 5;

   logic       sys_clk = 1'b0;
   logic       sys_reset = 1'b1;
   logic [5:0] btn_raw = '0;
   logic       game_tick = 1'b0;
   logic [1:0] cur_dir;
   logic       dir_changed, sp_pulse, gr_pulse, dir_drop;
   logic [2:0] q_count;

   int vectors = 0;
   int miscompares = 0;
   int drop_cnt = 0, chg_cnt = 0, sp_cnt = 0;

   always #5 sys_clk = ~sys_clk;

   snake_input_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .QUEUE_DEPTH     (QD),
      .INIT_DIR        (2'd0)
   ) dut (
      .sys_clk                (sys_clk),
      .sys_reset              (sys_reset),
      .btn_up_raw_in          (btn_raw[B_UP]),
      .btn_down_raw_in        (btn_raw[B_DOWN]),
      .btn_left_raw_in        (btn_raw[B_LEFT]),
      .btn_right_raw_in       (btn_raw[B_RIGHT]),
      .btn_start_pause_raw_in (btn_raw[B_SP]),
      .btn_game_reset_raw_in  (btn_raw[B_GR]),
      .game_tick_in           (game_tick),
      .cur_dir_out            (cur_dir),
      .dir_changed_out        (dir_changed),
      .start_pause_pulse_out  (sp_pulse),
      .game_reset_pulse_out   (gr_pulse),
      .queue_count_out        (q_count),
      .dir_drop_out           (dir_drop)
   );

   always @(negedge sys_clk) begin
      if (!sys_reset) begin
         if (dir_drop)    drop_cnt++;
         if (dir_changed) chg_cnt++;
         if (sp_pulse)    sp_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic press(input int b);
      @(negedge sys_clk);
      btn_raw[b] = 1'b1;
      repeat (6) @(negedge sys_clk);
      btn_raw[b] = 1'b0;
      repeat (10) @(negedge sys_clk);
   endtask

   task automatic tick_once();
      @(negedge sys_clk);
      game_tick = 1'b1;
      @(negedge sys_clk);
      game_tick = 1'b0;
      @(negedge sys_clk);
   endtask

   typedef struct {
      int op;          // 0 = press btn, 1 = game tick
      int btn;
      int exp_count;
      int exp_dir;
      int d_drop;
      int d_chg;
      int d_sp;
   } vec_t;

   vec_t vecs [16];

   // Behavioural model state for the randomized run
   bit [7:0]   m_hist [6];
   bit [5:0]   m_stable, m_stable_old, m_pulse;
   logic [1:0] m_q [$];
   logic [1:0] m_cur;
   bit         m_chg, m_drop;

   task automatic model_reset();
      for (int b = 0; b < 6; b++) m_hist[b] = '0;
      m_stable = '0;
      m_stable_old = '0;
      m_pulse = '0;
      m_q.delete();
      m_cur = 2'd0;
      m_chg = 1'b0;
      m_drop = 1'b0;
   endtask

   // Stable level flips once the DB synchronised samples leading up to this
   // edge all disagree with it (raw samples two edges older due to the synchroniser).
   task automatic model_step(input bit [5:0] r, input bit t);
      bit [5:0]   n_stable, n_pulse;
      bit         flip, cand_v, pop, accept, room;
      logic [1:0] cand, refd;
      for (int b = 0; b < 6; b++) begin
         flip = 1'b1;
         for (int j = 1; j <= DB; j++) begin
            if (m_hist[b][j] == m_stable[b]) flip = 1'b0;
         end
         n_stable[b] = flip ? ~m_stable[b] : m_stable[b];
         n_pulse[b]  = m_stable[b] & ~m_stable_old[b];
         m_hist[b]   = {m_hist[b][6:0], r[b]};
      end
      m_chg  = 1'b0;
      m_drop = 1'b0;
      if (m_pulse[B_GR]) begin
         m_q.delete();
         m_cur = 2'd0;
      end else begin
         cand_v = |m_pulse[3:0];
         cand = m_pulse[0] ? 2'd0 : m_pulse[1] ? 2'd1 : m_pulse[2] ? 2'd2 : 2'd3;
         refd = (m_q.size() > 0) ? m_q[$] : m_cur;
         pop = t && (m_q.size() > 0);
         accept = cand_v && (cand != refd) && (cand != (refd ^ 2'b01));
         room = (m_q.size() < QD) || pop;
         if (pop) begin
            m_cur = m_q.pop_front();
            m_chg = 1'b1;
         end
         if (accept && room) m_q.push_back(cand);
         else if (cand_v) m_drop = 1'b1;
      end
      m_stable_old = m_stable;
      m_stable = n_stable;
      m_pulse = n_pulse;
   endtask

   initial begin
      int d0, c0, s0;
      bit t;

      vecs[0]  = '{0, B_DOWN,  0, 0, 1, 0, 0};
      vecs[1]  = '{0, B_UP,    0, 0, 1, 0, 0};
      vecs[2]  = '{0, B_LEFT,  1, 0, 0, 0, 0};
      vecs[3]  = '{1, 0,       0, 2, 0, 1, 0};
      vecs[4]  = '{0, B_GR,    0, 0, 0, 0, 0};
      vecs[5]  = '{0, B_LEFT,  1, 0, 0, 0, 0};
      vecs[6]  = '{0, B_DOWN,  2, 0, 0, 0, 0};
      vecs[7]  = '{0, B_RIGHT, 3, 0, 0, 0, 0};
      vecs[8]  = '{0, B_UP,    4, 0, 0, 0, 0};
      vecs[9]  = '{0, B_LEFT,  4, 0, 1, 0, 0};
      vecs[10] = '{1, 0,       3, 2, 0, 1, 0};
      vecs[11] = '{1, 0,       2, 1, 0, 1, 0};
      vecs[12] = '{1, 0,       1, 3, 0, 1, 0};
      vecs[13] = '{1, 0,       0, 0, 0, 1, 0};
      vecs[14] = '{1, 0,       0, 0, 0, 0, 0};
      vecs[15] = '{0, B_SP,    0, 0, 0, 0, 1};

      #12;
      chk("in-reset count", int'(q_count), 0);
      chk("in-reset dir", int'(cur_dir), 0);
      @(negedge sys_clk);
      sys_reset = 1'b0;
      repeat (2) @(negedge sys_clk);
      chk("reset count", int'(q_count), 0);
      chk("reset dir", int'(cur_dir), 0);
      chk("reset pulses", int'({dir_changed, sp_pulse, gr_pulse, dir_drop}), 0);

      for (int i = 0; i < 16; i++) begin
         d0 = drop_cnt; c0 = chg_cnt; s0 = sp_cnt;
         if (vecs[i].op == 0) press(vecs[i].btn);
         else tick_once();
         chk($sformatf("row%0d count", i), int'(q_count), vecs[i].exp_count);
         chk($sformatf("row%0d dir", i), int'(cur_dir), vecs[i].exp_dir);
         chk($sformatf("row%0d drops", i), drop_cnt - d0, vecs[i].d_drop);
         chk($sformatf("row%0d changes", i), chg_cnt - c0, vecs[i].d_chg);
         chk($sformatf("row%0d start pulses", i), sp_cnt - s0, vecs[i].d_sp);
      end

      // Glitch rejection and push latency, with cur_dir=LEFT so DOWN is accepted
      press(B_LEFT);
      tick_once();
      chk("glitch pre dir", int'(cur_dir), 2);
      d0 = drop_cnt;
      @(negedge sys_clk);
      btn_raw[B_DOWN] = 1'b1;
      @(negedge sys_clk);
      btn_raw[B_DOWN] = 1'b0;
      repeat (3) @(negedge sys_clk);
      btn_raw[B_DOWN] = 1'b1;
      repeat (3) @(negedge sys_clk);
      btn_raw[B_DOWN] = 1'b0;
      repeat (10) @(negedge sys_clk);
      chk("glitch count", int'(q_count), 0);
      chk("glitch drops", drop_cnt - d0, 0);
      @(negedge sys_clk);
      btn_raw[B_DOWN] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge sys_clk);
         #1;
         if (i == 7) chk("latency edge7 count", int'(q_count), 0);
         if (i == 8) chk("latency edge8 count", int'(q_count), 1);
      end
      repeat (12) @(negedge sys_clk);
      btn_raw[B_DOWN] = 1'b0;
      repeat (10) @(negedge sys_clk);
      chk("held single entry", int'(q_count), 1);
      tick_once();
      chk("held pop dir", int'(cur_dir), 1);

      // Full queue: accepted press and tick in the same cycle
      press(B_LEFT);
      press(B_UP);
      press(B_RIGHT);
      press(B_DOWN);
      chk("full count", int'(q_count), 4);
      @(negedge sys_clk);
      btn_raw[B_LEFT] = 1'b1;
      repeat (7) @(negedge sys_clk);
      game_tick = 1'b1;
      @(posedge sys_clk);
      #1;
      chk("push+pop count", int'(q_count), 4);
      chk("push+pop dir", int'(cur_dir), 2);
      chk("push+pop changed", int'(dir_changed), 1);
      chk("push+pop drop", int'(dir_drop), 0);
      @(negedge sys_clk);
      game_tick = 1'b0;
      repeat (2) @(negedge sys_clk);
      btn_raw[B_LEFT] = 1'b0;
      repeat (10) @(negedge sys_clk);
      chk("push+pop settle count", int'(q_count), 4);

      // Game reset with three entries queued and a non-initial direction
      tick_once();
      tick_once();
      chk("pre-gr dir", int'(cur_dir), 3);
      press(B_UP);
      chk("pre-gr count", int'(q_count), 3);
      @(negedge sys_clk);
      btn_raw[B_GR] = 1'b1;
      repeat (7) @(posedge sys_clk);
      #1;
      chk("gr pulse", int'(gr_pulse), 1);
      chk("gr pulse count", int'(q_count), 3);
      @(posedge sys_clk);
      #1;
      chk("gr flush count", int'(q_count), 0);
      chk("gr flush dir", int'(cur_dir), 0);
      chk("gr no changed", int'(dir_changed), 0);
      @(negedge sys_clk);
      btn_raw[B_GR] = 1'b0;
      repeat (10) @(negedge sys_clk);

      // Asynchronous reset mid-debounce with entries queued
      press(B_LEFT);
      press(B_DOWN);
      chk("pre-rst count", int'(q_count), 2);
      @(negedge sys_clk);
      btn_raw[B_RIGHT] = 1'b1;
      repeat (3) @(posedge sys_clk);
      #3;
      sys_reset = 1'b1;
      #1;
      chk("async rst count", int'(q_count), 0);
      chk("async rst dir", int'(cur_dir), 0);
      chk("async rst pulses", int'({dir_changed, sp_pulse, gr_pulse, dir_drop}), 0);
      @(negedge sys_clk);
      btn_raw[B_RIGHT] = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_reset = 1'b0;
      d0 = drop_cnt;
      repeat (15) @(negedge sys_clk);
      chk("post-rst count", int'(q_count), 0);
      chk("post-rst dir", int'(cur_dir), 0);
      chk("post-rst drops", drop_cnt - d0, 0);

      // Randomized run against the behavioural model
      @(negedge sys_clk);
      sys_reset = 1'b1;
      btn_raw = '0;
      game_tick = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_reset = 1'b0;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         @(negedge sys_clk);
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
         end
         if ($urandom_range(0, 19) == 0) btn_raw[B_SP] = ~btn_raw[B_SP];
         if ($urandom_range(0, 199) == 0) btn_raw[B_GR] = ~btn_raw[B_GR];
         t = ($urandom_range(0, 5) == 0);
         game_tick = t;
         @(posedge sys_clk);
         model_step(btn_raw, t);
         #1;
         chk($sformatf("rnd%0d dir", n), int'(cur_dir), int'(m_cur));
         chk($sformatf("rnd%0d count", n), int'(q_count), m_q.size());
         chk($sformatf("rnd%0d changed", n), int'(dir_changed), int'(m_chg));
         chk($sformatf("rnd%0d drop", n), int'(dir_drop), int'(m_drop));
         chk($sformatf("rnd%0d start pulse", n), int'(sp_pulse), int'(m_pulse[B_SP]));
         chk($sformatf("rnd%0d reset pulse", n), int'(gr_pulse), int'(m_pulse[B_GR]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
